prim_edge_evt_arb: RTL

PRIM_EDGE_EVT_ARB -- requirements
Module: prim_edge_evt_arb

---
 rtl/prim_edge_evt_arb.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/prim_edge_evt_arb.sv
// rtl/prim_edge_evt_arb.sv - debounced per-channel edge detector with round-robin event arbiter
// Channels are debounced, edges latched as pending flags, then offered one at a time.
module prim_edge_evt_arb #(
  parameter int NumCh     = 4,
  parameter int DebCycles = 3,
  localparam int ChW      = (NumCh > 1) ? $clog2(NumCh) : 1,
  localparam int CntW     = (DebCycles > 1) ? $clog2(DebCycles) : 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic [NumCh-1:0] serial_i,
  input  logic [NumCh-1:0] rise_en_i,
  input  logic [NumCh-1:0] fall_en_i,
  input  logic             clr_ovf_i,
  input  logic             evt_ready_i,
  output logic             evt_valid_o,
  output logic [ChW-1:0]   evt_ch_o,
  output logic             evt_rise_o,
  output logic [NumCh-1:0] pending_o,
  output logic             overflow_o
);

  localparam int ChW1 = ChW + 1;

  typedef enum logic {IDLE, OFFER} state_e;

  state_e            state_q;
  logic [NumCh-1:0]  stable_q;
  logic [NumCh-1:0]  stable_d1_q;
  logic [CntW-1:0]   cnt_q [NumCh];
  logic [NumCh-1:0]  rise_pend_q;
  logic [NumCh-1:0]  fall_pend_q;
  logic [ChW-1:0]    ptr_q;
  logic              evt_valid_q;
  logic [ChW-1:0]    evt_ch_q;
  logic              evt_rise_q;
  logic              overflow_q;

  logic [NumCh-1:0]  rise_evt;
  logic [NumCh-1:0]  fall_evt;
  logic              grant;
  logic              grant_rise;
  logic [ChW-1:0]    grant_ch;
  logic [ChW:0]      scan_idx;
  logic [ChW:0]      ptr_sum;
  logic [ChW-1:0]    ptr_nxt;
  logic [NumCh-1:0]  grant_oh;
  logic [NumCh-1:0]  rise_clr;
  logic [NumCh-1:0]  fall_clr;
  logic              ovf_set;

  // While disabled, stable and its delayed copy both follow raw so re-enabling sees no edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stable_q    <= '0;
      stable_d1_q <= '0;
      for (int i = 0; i < NumCh; i++) cnt_q[i] <= '0;
    end else if (!en_i) begin
      stable_q    <= serial_i;
      stable_d1_q <= serial_i;
      for (int i = 0; i < NumCh; i++) cnt_q[i] <= '0;
    end else begin
      stable_d1_q <= stable_q;
      for (int i = 0; i < NumCh; i++) begin
        if (serial_i[i] == stable_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CntW'(DebCycles - 1)) begin
          stable_q[i] <= serial_i[i];
          cnt_q[i]    <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  assign rise_evt = {NumCh{en_i}} &  stable_q & ~stable_d1_q & rise_en_i;
  assign fall_evt = {NumCh{en_i}} & ~stable_q &  stable_d1_q & fall_en_i;

  // Round-robin scan from ptr; rise wins over fall inside one channel.
  always_comb begin
    grant      = 1'b0;
    grant_rise = 1'b0;
    grant_ch   = '0;
    scan_idx   = '0;
    for (int i = 0; i < NumCh; i++) begin
      scan_idx = {1'b0, ptr_q} + ChW1'(i);
      if (scan_idx >= ChW1'(NumCh)) scan_idx = scan_idx - ChW1'(NumCh);
      if (!grant && (rise_pend_q[scan_idx[ChW-1:0]] || fall_pend_q[scan_idx[ChW-1:0]])) begin
        grant      = 1'b1;
        grant_ch   = scan_idx[ChW-1:0];
        grant_rise = rise_pend_q[scan_idx[ChW-1:0]];
      end
    end
    if (state_q != IDLE) grant = 1'b0;
  end

  always_comb begin
    ptr_sum = {1'b0, grant_ch} + ChW1'(1);
    ptr_nxt = (ptr_sum == ChW1'(NumCh)) ? '0 : ptr_sum[ChW-1:0];
  end

  assign grant_oh = grant ? (NumCh'(1) << grant_ch) : '0;
  assign rise_clr = grant_rise ? grant_oh : '0;
  assign fall_clr = grant_rise ? '0 : grant_oh;

  // A fresh edge landing on the cycle its flag is granted simply re-arms the flag.
  assign ovf_set = (|(rise_evt & rise_pend_q & ~rise_clr)) |
                   (|(fall_evt & fall_pend_q & ~fall_clr));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rise_pend_q <= '0;
      fall_pend_q <= '0;
      overflow_q  <= 1'b0;
    end else begin
      rise_pend_q <= (rise_pend_q & ~rise_clr) | rise_evt;
      fall_pend_q <= (fall_pend_q & ~fall_clr) | fall_evt;
      overflow_q  <= ovf_set | (overflow_q & ~clr_ovf_i);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      evt_valid_q <= 1'b0;
      evt_ch_q    <= '0;
      evt_rise_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant) begin
            evt_valid_q <= 1'b1;
            evt_ch_q    <= grant_ch;
            evt_rise_q  <= grant_rise;
            ptr_q       <= ptr_nxt;
            state_q     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready_i) begin
            evt_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_ch_o    = evt_ch_q;
  assign evt_rise_o  = evt_rise_q;
  assign pending_o   = rise_pend_q | fall_pend_q;
  assign overflow_o  = overflow_q;

endmodule
